// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation modes and
// burst sequencer states.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational next-value function of the shift register for one step of
// the selected mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q_next
);

  // Select the next register value for the requested operation.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = par_in;
      MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
      MODE_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = {WIDTH{1'b0}};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_register_universal.sv
// N-bit universal shift register with single-step operation and a counted
// burst sequencer reporting busy/done.
module shift_register_universal
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r, state_nx_s;
  logic [WIDTH-1:0] q_r, q_nx_s, q_step_s;
  logic [CNT_W-1:0] rem_r, rem_nx_s;
  logic [2:0]       mode_lat_r, mode_lat_nx_s, step_mode_s;
  logic             done_r, done_nx_s;

  // Bursts run the latched mode; the live mode only drives single steps.
  assign step_mode_s = (state_r == ST_BURST) ? mode_lat_r : mode;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q        (q_r),
    .mode     (step_mode_s),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .par_in   (par_in),
    .q_next   (q_step_s)
  );

  // Sequencer next-state and datapath next-value selection.
  always_comb begin
    state_nx_s    = state_r;
    q_nx_s        = q_r;
    rem_nx_s      = rem_r;
    mode_lat_nx_s = mode_lat_r;
    done_nx_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (cnt != CNT_ZERO) begin
            state_nx_s    = ST_BURST;
            rem_nx_s      = cnt;
            mode_lat_nx_s = mode;
          end else begin
            done_nx_s = 1'b1;
          end
        end else if (en) begin
          q_nx_s = q_step_s;
        end else begin
          q_nx_s = q_r;
        end
      end
      ST_BURST: begin
        if (en) begin
          q_nx_s   = q_step_s;
          rem_nx_s = rem_r - CNT_ONE;
          if (rem_r == CNT_ONE) begin
            state_nx_s = ST_IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_BURST;
          end
        end else begin
          q_nx_s = q_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        rem_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and status registers; reset aborts any burst silently.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r    <= ST_IDLE;
      q_r        <= {WIDTH{1'b0}};
      rem_r      <= CNT_ZERO;
      mode_lat_r <= MODE_HOLD;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      q_r        <= q_nx_s;
      rem_r      <= rem_nx_s;
      mode_lat_r <= mode_lat_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign q         = q_r;
  assign ser_out_l = q_r[WIDTH-1];
  assign ser_out_r = q_r[0];
  assign busy      = (state_r == ST_BURST);
  assign done      = done_r;

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (WIDTH=4): directed test
// plan steps followed by randomized traffic against an arithmetic model.
module tb_shift_register_universal;

  localparam int W = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic         start = 1'b0;
  logic [2:0]   cnt = 3'd0;
  logic         ser_in_l = 1'b0;
  logic         ser_in_r = 1'b0;
  logic [W-1:0] par_in = 4'd0;
  logic [W-1:0] q;
  logic         ser_out_l, ser_out_r, busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: register value as an integer 0..15 and burst status.
  int m_q = 0;
  int m_rem = 0;
  int m_mode = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  shift_register_universal #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .start(start), .cnt(cnt),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .par_in(par_in),
    .q(q), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int apply_op(int op, int v, int sl, int sr, int p);
    case (op)
      1: return p;
      2: return (v * 2) % M + sr;
      3: return v / 2 + sl * (M / 2);
      4: return (v * 2) % M + v / (M / 2);
      5: return v / 2 + (v % 2) * (M / 2);
      6: return v / 2 + ((v >= M / 2) ? M / 2 : 0);
      7: return 0;
      default: return v;
    endcase
  endfunction

  task automatic model_edge();
    if (m_busy) begin
      m_done = 1'b0;
      if (en) begin
        m_q = apply_op(m_mode, m_q, int'(ser_in_l), int'(ser_in_r), int'(par_in));
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        if (cnt == 3'd0) m_done = 1'b1;
        else begin
          m_busy = 1'b1;
          m_rem  = int'(cnt);
          m_mode = int'(mode);
        end
      end else if (en) begin
        m_q = apply_op(int'(mode), m_q, int'(ser_in_l), int'(ser_in_r), int'(par_in));
      end
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".sol"}, 32'(ser_out_l), 32'(m_q / (M / 2)));
    chk({tag, ".sor"}, 32'(ser_out_r), 32'(m_q % 2));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic load(input logic [W-1:0] v);
    start = 1'b0; en = 1'b1; mode = 3'd1; par_in = v;
    step("load");
  endtask

  // Asynchronous reset one time unit after an edge, released before the next edge.
  task automatic mid_reset(input string tag);
    clr = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    #2;
    clr = 1'b1;
  endtask

  initial begin
    #3;
    chk_all("rst_async");
    @(posedge clk); #1;
    chk_all("rst_hold");
    clr = 1'b1;

    // Reset and load
    en = 1'b1; mode = 3'd1; par_in = 4'b1011;
    step("load1011");
    chk("load1011.const", 32'(q), 32'hb);

    // Serial fill
    load(4'b0000);
    mode = 3'd2; ser_in_r = 1'b1;
    step("shl1"); chk("shl1.const", 32'(q), 32'h1);
    step("shl2"); chk("shl2.const", 32'(q), 32'h3);
    step("shl3"); chk("shl3.const", 32'(q), 32'h7);
    step("shl4"); chk("shl4.const", 32'(q), 32'hf);
    chk("shl4.sol", 32'(ser_out_l), 32'h1);

    // Rotate and arithmetic shift
    load(4'b1001);
    mode = 3'd5; step("ror"); chk("ror.const", 32'(q), 32'hc);
    mode = 3'd4; step("rol"); chk("rol.const", 32'(q), 32'h9);
    mode = 3'd6; step("asr1"); chk("asr1.const", 32'(q), 32'hc);
    step("asr2"); chk("asr2.const", 32'(q), 32'he);

    // Burst with stall; mode changes during the burst are ignored
    load(4'b0001);
    start = 1'b1; cnt = 3'd3; mode = 3'd4;
    step("b_start"); chk("b_start.busy", 32'(busy), 32'h1);
    start = 1'b0; mode = 3'd3;
    step("b_s1"); chk("b_s1.const", 32'(q), 32'h2);
    en = 1'b0; mode = 3'd7;
    step("b_stall1");
    step("b_stall2"); chk("b_stall2.const", 32'(q), 32'h2);
    en = 1'b1; mode = 3'd1;
    step("b_s2"); chk("b_s2.const", 32'(q), 32'h4);
    step("b_s3"); chk("b_s3.const", 32'(q), 32'h8);
    chk("b_s3.done", 32'(done), 32'h1);
    en = 1'b0;
    step("b_after"); chk("b_after.done", 32'(done), 32'h0);

    // Zero-count, then back-to-back start in the done cycle
    load(4'b0000);
    start = 1'b1; cnt = 3'd0; mode = 3'd2;
    step("z_start"); chk("z_start.done", 32'(done), 32'h1);
    cnt = 3'd2; mode = 3'd3; ser_in_l = 1'b1;
    step("bb_start"); chk("bb_start.busy", 32'(busy), 32'h1);
    start = 1'b0;
    step("bb_s1"); chk("bb_s1.const", 32'(q), 32'h8);
    step("bb_s2"); chk("bb_s2.const", 32'(q), 32'hc);
    chk("bb_s2.done", 32'(done), 32'h1);

    // Reset mid-burst: no done pulse afterwards
    start = 1'b1; cnt = 3'd7; mode = 3'd4;
    step("r_start");
    start = 1'b0;
    step("r_s1");
    step("r_s2");
    mid_reset("r_clr");
    chk("r_clr.const", 32'(q), 32'h0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("r_post");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(3) != 0);
      mode     = 3'($urandom_range(7));
      start    = ($urandom_range(5) == 0);
      cnt      = 3'($urandom_range(7));
      ser_in_l = 1'($urandom_range(1));
      ser_in_r = 1'($urandom_range(1));
      par_in   = 4'($urandom_range(15));
      if ($urandom_range(60) == 0) mid_reset("rnd_clr");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised N-bit universal shift register, the successor to the fixed 4-bit serial-in shifter.
- Supports hold, parallel load, logical shifts, rotates, arithmetic right shift and synchronous clear, applied either as single steps or as counted bursts.
- A burst sequencer gives busy/done status, so upstream control logic can issue "shift K places" without counting clocks itself.
- Used as the shared shift datapath for serialiser/deserialiser and LED/pattern blocks.

Parameters:
- WIDTH, 4: register width in bits; must be at least 2.
- CNT_W, 3: width of the burst count input; maximum burst is 2^CNT_W-1 steps.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- en  in  1  step enable; when low, q and the burst counter freeze.
- mode  in  3  operation select; encoding below.
- start  in  1  burst request; sampled in IDLE only.
- cnt  in  CNT_W  burst step count; sampled with start.
- ser_in_l  in  1  serial bit entering the MSB side (SHR).
- ser_in_r  in  1  serial bit entering the LSB side (SHL).
- par_in  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- ser_out_l  out  1  q[WIDTH-1].
- ser_out_r  out  1  q[0].
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (clr=0, asynchronous): q=0, busy=0, done=0, state=IDLE, remaining count=0. Reset mid-burst aborts the burst; no done pulse follows.
- Mode encoding (shared package):
  - 0 HOLD.
  - 1 LOAD: q<=par_in.
  - 2 SHL: q<={q[W-2:0],ser_in_r}.
  - 3 SHR: q<={ser_in_l,q[W-1:1]}.
  - 4 ROL: q<={q[W-2:0],q[W-1]}.
  - 5 ROR: q<={q[0],q[W-1:1]}.
  - 6 ASR: q<={q[W-1],q[W-1:1]}.
  - 7 CLR: q<=0 (synchronous).
- ser_out_l and ser_out_r are combinational from q. No extra latency: a step is visible on q after the edge that applies it.
- States:
  - IDLE, start=0: if en=1, the live mode is applied once per edge (single-step). If en=0, q holds.
  - IDLE, start=1, cnt>0: mode and cnt are latched; no step is applied on this edge; next state is BURST; busy=1 from the next cycle.
  - IDLE, start=1, cnt=0: no change to q; done=1 for the following cycle; busy stays 0.
  - BURST: each edge with en=1 applies the latched mode, using live ser_in_l, ser_in_r and par_in, and decrements remaining. The live mode and start inputs are ignored. With en=0, nothing changes.
  - BURST, remaining=1 and en=1: the final step is applied; the state returns to IDLE; busy=0 and done=1 for exactly one cycle after that edge.
- done is registered and never held longer than one cycle.
- start in the cycle done=1 is accepted, since the state is IDLE.
- The count is unsigned. A burst of K steps completes K enabled edges after the start edge.
- Rotates and shifts never change width. Shifts on the last step drop the bit shifted out.

Decomposition:
- Package shift_pkg holds:
  - the mode encoding localparams (MODE_HOLD..MODE_CLR);
  - the state encoding (ST_IDLE, ST_BURST).
- One natural sub-module, shift_step: purely combinational next-value function taking (q, mode, ser_in_l, ser_in_r, par_in) and returning next q.
- The top level holds the registers and the burst sequencer.

Test Plan:
All scenarios use WIDTH=4.
- Reset and load: clr=0 then release; mode=LOAD, par_in=4'b1011, en=1 for one edge -> q=0000 during reset, then q=1011; busy=0, done=0 throughout.
- Serial fill (legacy 4-bit behaviour): q=0000, mode=SHL, ser_in_r=1, four single steps -> q=0001, 0011, 0111, 1111; ser_out_l=1 after the 4th step.
- Rotate and arithmetic shift: q=1001; ROR once -> 1100; ROL once -> 1001; ASR twice -> 1100, then 1110.
- Burst with stall: q=0001, start=1, cnt=3, mode=ROL; en low for 2 cycles mid-burst -> busy=1 for 5 cycles; q=0010, 0100, 1000; done pulses once after the 3rd enabled step; mode changes during the burst are ignored.
- Zero-count and back-to-back: start with cnt=0 -> done pulse next cycle, q unchanged, busy=0; start with cnt=2 (SHR, ser_in_l=1) in the done cycle -> accepted, q 0000 -> 1000 -> 1100.
- Reset mid-burst: start cnt=7 ROL, assert clr after 2 steps -> q=0, busy=0 immediately; no done pulse after release.
